// File: rtl/alu_seq.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides.
// MULU and DIVU take one shift-add / restoring-subtract step per cycle; all other ops finish in one cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             zf,
    output logic             of,
    output logic             dz
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_MULU = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH-1:0] sc_c;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_of;
    logic             sc_dz;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // Single-cycle results, computed straight from the request operands
    always_comb begin
        sum   = a + b;
        diff  = a - b;
        sc_c  = '0;
        sc_hi = '0;
        sc_of = 1'b0;
        sc_dz = 1'b0;
        unique case (alu_ctrl)
            OP_AND:  sc_c = a & b;
            OP_OR:   sc_c = a | b;
            OP_SLTU: sc_c = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_ADD: begin
                sc_c  = sum;
                sc_of = (a[WIDTH-1] & b[WIDTH-1] & ~sum[WIDTH-1])
                      | (~a[WIDTH-1] & ~b[WIDTH-1] & sum[WIDTH-1]);
            end
            OP_ADDU: sc_c = sum;
            OP_SUB: begin
                sc_c  = diff;
                sc_of = (a[WIDTH-1] & ~b[WIDTH-1] & ~diff[WIDTH-1])
                      | (~a[WIDTH-1] & b[WIDTH-1] & diff[WIDTH-1]);
            end
            OP_DIVU: begin
                sc_c  = '1;
                sc_hi = a;
                sc_dz = 1'b1;
            end
            default: sc_c = '0;
        endcase
    end

    // One iteration: {hi,lo} is the product/multiplier pair or the remainder/quotient pair
    always_comb begin
        add_w   = {1'b0, hi_q} + {1'b0, opnd_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        sub_w   = shifted - {1'b0, opnd_q};
        hi_n    = hi_q;
        lo_n    = lo_q;
        if (is_div) begin
            if (!sub_w[WIDTH]) begin
                hi_n = sub_w[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            hi_n = add_w[WIDTH:1];
            lo_n = {add_w[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_n = {1'b0, hi_q[WIDTH-1:1]};
            lo_n = {hi_q[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c         <= '0;
            c_hi      <= '0;
            zf        <= 1'b0;
            of        <= 1'b0;
            dz        <= 1'b0;
            cnt       <= '0;
            is_div    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (alu_ctrl == OP_MULU) begin
                            hi_q   <= '0;
                            lo_q   <= b;
                            opnd_q <= a;
                            is_div <= 1'b0;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= BUSY;
                        end else if (alu_ctrl == OP_DIVU && b != '0) begin
                            hi_q   <= '0;
                            lo_q   <= a;
                            opnd_q <= b;
                            is_div <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= BUSY;
                        end else begin
                            c         <= sc_c;
                            c_hi      <= sc_hi;
                            zf        <= (sc_c == '0);
                            of        <= sc_of;
                            dz        <= sc_dz;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    hi_q <= hi_n;
                    lo_q <= lo_n;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        c         <= lo_n;
                        c_hi      <= hi_n;
                        zf        <= (lo_n == '0);
                        of        <= 1'b0;
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors, randomized ops against an arithmetic model,
// result stall with ignored requests, and reset abort mid-multiply.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic [31:0] c_hi;
    logic        zf;
    logic        of;
    logic        dz;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_hi      (c_hi),
        .zf        (zf),
        .of        (of),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] ec, output logic [31:0] eh,
                         output logic ez, output logic eo, output logic ed, output int el);
        longint s;
        logic [63:0] p;
        longint hi_lim = 64'sh7FFF_FFFF;
        longint lo_lim = -64'sh8000_0000;
        ec = 32'h0; eh = 32'h0; eo = 1'b0; ed = 1'b0; el = 1;
        case (op)
            3'd0: ec = x & y;
            3'd1: ec = x | y;
            3'd2: begin p = 64'(x) * 64'(y); ec = p[31:0]; eh = p[63:32]; el = 33; end
            3'd3: ec = (x < y) ? 32'd1 : 32'd0;
            3'd4: begin
                s = longint'($signed(x)) + longint'($signed(y));
                ec = x + y; eo = (s > hi_lim) || (s < lo_lim);
            end
            3'd5: ec = x + y;
            3'd6: begin
                s = longint'($signed(x)) - longint'($signed(y));
                ec = x - y; eo = (s > hi_lim) || (s < lo_lim);
            end
            default: begin
                if (y == 32'h0) begin ec = 32'hFFFF_FFFF; eh = x; ed = 1'b1; end
                else begin ec = x / y; eh = x % y; el = 33; end
            end
        endcase
        ez = (ec == 32'h0);
    endtask

    // Drives one full transaction; reports results, latency and handshake anomalies
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int stall,
                          output logic [31:0] rc, output logic [31:0] rh,
                          output logic rz, output logic ro, output logic rd, output int lat,
                          output bit ready_bad, output bit unstable, output bit after_bad);
        ready_bad = 0; unstable = 0; after_bad = 0;
        if (!in_ready) ready_bad = 1;
        in_valid = 1'b1; alu_ctrl = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_ctrl = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_bad = 1;
            in_valid = 1'($urandom); a = $urandom; b = $urandom; alu_ctrl = 3'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        rc = c; rh = c_hi; rz = zf; ro = of; rd = dz;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; alu_ctrl = 3'($urandom);
            out_ready = 1'b0;
            @(posedge clk); #1;
            if (!out_valid || in_ready || c !== rc || c_hi !== rh || zf !== rz || of !== ro || dz !== rd)
                unstable = 1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid || !in_ready) after_bad = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; alu_ctrl = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, c, c_hi, zf, of, dz} !== {1'b1, 1'b0, 32'h0, 32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%b vld=%b c=%h hi=%h zf=%b of=%b dz=%b required rdy=1 vld=0 all zero",
                     in_ready, out_valid, c, c_hi, zf, of, dz);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [10] = '{3'd4, 3'd6, 3'd3, 3'd0, 3'd1, 3'd2, 3'd7, 3'd7, 3'd6, 3'd5};
        logic [31:0] t_a  [10] = '{32'h7FFF_FFFF, 32'h5, 32'h1, 32'hF0F0, 32'hF0F0,
                                   32'hFFFF_FFFF, 32'h100, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] t_b  [10] = '{32'h1, 32'h5, 32'hFFFF_FFFF, 32'h0FF0, 32'h0FF0,
                                   32'h2, 32'h7, 32'h0, 32'h1, 32'h1};
        logic [31:0] t_c  [10] = '{32'h8000_0000, 32'h0, 32'h1, 32'h00F0, 32'hFFF0,
                                   32'hFFFF_FFFE, 32'd36, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [31:0] t_h  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h1, 32'd4, 32'h1234_5678, 32'h0, 32'h0};
        logic [2:0]  t_f  [10] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b000,
                                   3'b000, 3'b000, 3'b001, 3'b010, 3'b000};
        int          t_l  [10] = '{1, 1, 1, 1, 1, 33, 33, 1, 1, 1};
        logic [31:0] rc, rh;
        logic rz, ro, rd;
        int lat;
        bit rb, us, ab;
        for (int i = 0; i < 10; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], 0, rc, rh, rz, ro, rd, lat, rb, us, ab);
            n_cmp++;
            if ({rc, rh, rz, ro, rd} !== {t_c[i], t_h[i], t_f[i]}) begin
                n_fail++;
                $display("FAIL directed[%0d] result: got c=%h hi=%h zf/of/dz=%b%b%b required c=%h hi=%h zf/of/dz=%b",
                         i, rc, rh, rz, ro, rd, t_c[i], t_h[i], t_f[i]);
            end
            n_cmp++;
            if (lat !== t_l[i] || rb || ab) begin
                n_fail++;
                $display("FAIL directed[%0d] timing: got latency=%0d ready_bad=%0b after_bad=%0b required latency=%0d 0 0",
                         i, lat, rb, ab, t_l[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, ec, eh, rc, rh;
        logic [2:0] op;
        logic ez, eo, ed, rz, ro, rd;
        int el, lat;
        bit rb, us, ab;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 5) == 0) x = y;
            model(op, x, y, ec, eh, ez, eo, ed, el);
            run_op(op, x, y, $urandom_range(0, 2), rc, rh, rz, ro, rd, lat, rb, us, ab);
            n_cmp++;
            if ({rc, rh, rz, ro, rd} !== {ec, eh, ez, eo, ed} || lat !== el || rb || us || ab) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got c=%h hi=%h f=%b%b%b lat=%0d hs=%0b%0b%0b required c=%h hi=%h f=%b%b%b lat=%0d hs=000",
                         i, op, x, y, rc, rh, rz, ro, rd, lat, rb, us, ab, ec, eh, ez, eo, ed, el);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] x, y, ec, eh, rc, rh;
        logic ez, eo, ed, rz, ro, rd;
        int el, lat;
        bit rb, us, ab;
        for (int k = 0; k < 3; k++) begin
            x = $urandom; y = $urandom;
            model(3'd2, x, y, ec, eh, ez, eo, ed, el);
            run_op(3'd2, x, y, 5, rc, rh, rz, ro, rd, lat, rb, us, ab);
            n_cmp++;
            if (us || rb) begin
                n_fail++;
                $display("FAIL stall[%0d] hold: got unstable=%0b ready_bad=%0b required 0 0", k, us, rb);
            end
            n_cmp++;
            if ({rc, rh} !== {ec, eh} || ab) begin
                n_fail++;
                $display("FAIL stall[%0d] result: got c=%h hi=%h after_bad=%0b required c=%h hi=%h 0",
                         k, rc, rh, ab, ec, eh);
            end
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        logic [31:0] rc, rh;
        logic rz, ro, rd;
        int lat;
        bit rb, us, ab;
        in_valid = 1'b1; alu_ctrl = 3'd2; a = 32'hDEAD_BEEF; b = 32'h1234_5679;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, out_valid, c, c_hi, zf, of, dz} !== {1'b1, 1'b0, 32'h0, 32'h0, 3'b000}) begin
            n_fail++;
            $display("FAIL abort reset: got rdy=%b vld=%b c=%h hi=%h f=%b%b%b required rdy=1 vld=0 all zero",
                     in_ready, out_valid, c, c_hi, zf, of, dz);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort idle: got spurious out_valid or in_ready low after abort, required idle");
        end
        run_op(3'd7, 32'd1000, 32'd33, 0, rc, rh, rz, ro, rd, lat, rb, us, ab);
        n_cmp++;
        if ({rc, rh, lat} !== {32'd30, 32'd10, 33}) begin
            n_fail++;
            $display("FAIL abort recover: got c=%0d hi=%0d lat=%0d required c=30 hi=10 lat=33", rc, rh, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
